// File: rtl/serial_seg_frame_drv.sv
// Serial frame driver for a shift-register 7-seg display. A frame takes 1 + 2*SCLK_HALF*NUM_DIGITS*SEG_W
// cycles from capture to done. There is no backpressure: update/refresh while busy queue one merged request.
module serial_seg_frame_drv #(
  parameter int NUM_DIGITS = 8,
  parameter int SEG_W      = 8,
  parameter int SCLK_HALF  = 1,
  parameter int REFRESH    = 100000,
  parameter int MSB_FIRST  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DIGITS*SEG_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]       blank,
  input  logic                        update,
  input  logic                        auto_en,
  output logic                        busy,
  output logic                        done,
  output logic                        seg_clk,
  output logic                        seg_dt,
  output logic                        seg_en,
  output logic                        seg_clr
);

  localparam int FRAME_W = NUM_DIGITS * SEG_W;
  localparam int BCNT_W  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int HCNT_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int RCNT_W  = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(FRAME_W - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(SCLK_HALF - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'((REFRESH > 0) ? REFRESH - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_t;

  state_t              state_q, state_d;
  logic                pending_q, pending_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                seg_clk_q, seg_clk_d;
  logic                seg_dt_q, seg_dt_d;
  logic                seg_en_q, seg_en_d;
  logic                seg_clr_q, seg_clr_d;

  logic [FRAME_W-1:0]  frame_in;
  logic [FRAME_W-1:0]  shreg_nxt;
  logic                refresh_req;
  logic                new_req;
  logic                start_req;
  logic                half_last;
  logic                bit_last;

  function automatic logic first_bit(input logic [FRAME_W-1:0] v);
    if (MSB_FIRST != 0) return v[FRAME_W-1];
    else                return v[0];
  endfunction

  // Blanked digits are forced dark (all-ones) before capture.
  always_comb begin
    frame_in = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      frame_in[k*SEG_W +: SEG_W] = blank[k] ? {SEG_W{1'b1}} : digits[k*SEG_W +: SEG_W];
    end
  end

  always_comb begin
    rcnt_d      = '0;
    refresh_req = 1'b0;
    if (REFRESH > 0 && auto_en) begin
      if (rcnt_q == RCNT_LAST) begin
        refresh_req = 1'b1;
      end else begin
        rcnt_d = rcnt_q + RCNT_W'(1);
      end
    end
  end

  assign new_req   = update | refresh_req;
  assign start_req = new_req | pending_q;
  assign half_last = (hcnt_q == HCNT_LAST);
  assign bit_last  = (bcnt_q == '0);
  assign shreg_nxt = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_req) state_d = ST_LOAD;
      ST_LOAD:     state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (half_last) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (half_last) state_d = bit_last ? ST_LATCH : ST_SHIFT_LO;
      ST_LATCH:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q | new_req;
    shreg_d   = shreg_q;
    bcnt_d    = bcnt_q;
    hcnt_d    = hcnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    seg_clk_d = seg_clk_q;
    seg_dt_d  = seg_dt_q;
    seg_en_d  = seg_en_q;
    seg_clr_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        // A request arriving together with a queued one still yields a single frame.
        pending_d = 1'b0;
        if (start_req) begin
          busy_d  = 1'b1;
          shreg_d = frame_in;
        end
      end
      ST_LOAD: begin
        bcnt_d    = BCNT_LAST;
        hcnt_d    = '0;
        seg_en_d  = 1'b0;
        seg_dt_d  = first_bit(shreg_q);
        seg_clk_d = 1'b0;
      end
      ST_SHIFT_LO: begin
        if (half_last) begin
          hcnt_d    = '0;
          seg_clk_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (half_last) begin
          hcnt_d = '0;
          if (bit_last) begin
            seg_en_d  = 1'b1;
            done_d    = 1'b1;
            seg_clk_d = 1'b1;
          end else begin
            bcnt_d    = bcnt_q - BCNT_W'(1);
            shreg_d   = shreg_nxt;
            seg_dt_d  = first_bit(shreg_nxt);
            seg_clk_d = 1'b0;
          end
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      ST_LATCH: begin
        busy_d    = 1'b0;
        seg_en_d  = 1'b1;
        seg_clk_d = 1'b1;
      end
      default: begin
        busy_d    = 1'b0;
        seg_en_d  = 1'b1;
        seg_clk_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      rcnt_q    <= '0;
      shreg_q   <= '0;
      bcnt_q    <= '0;
      hcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      seg_clk_q <= 1'b1;
      seg_dt_q  <= 1'b0;
      seg_en_q  <= 1'b1;
      seg_clr_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rcnt_q    <= rcnt_d;
      shreg_q   <= shreg_d;
      bcnt_q    <= bcnt_d;
      hcnt_q    <= hcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      seg_clk_q <= seg_clk_d;
      seg_dt_q  <= seg_dt_d;
      seg_en_q  <= seg_en_d;
      seg_clr_q <= seg_clr_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign seg_clk = seg_clk_q;
  assign seg_dt  = seg_dt_q;
  assign seg_en  = seg_en_q;
  assign seg_clr = seg_clr_q;

endmodule

// File: tb/tb_serial_seg_frame_drv.sv
// Four driver configurations share one stimulus stream; a transaction-level model predicts busy/done
// timing and the frame each one must shift out, and a monitor rebuilds frames from seg_clk rising edges.
module tb_serial_seg_frame_drv;

  localparam int NI = 4;
  localparam int NW = 16;
  // Per-instance SCLK_HALF, MSB_FIRST, REFRESH (must match the instances below).
  localparam int H_P [NI] = '{1, 2, 1, 1};
  localparam int M_P [NI] = '{1, 0, 1, 1};
  localparam int R_P [NI] = '{0, 0, 50, 20};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   digits;
  logic [1:0]    blank;
  logic          update;
  logic          auto_en;
  logic [NI-1:0] busy_w, done_w, sclk_w, sdt_w, sen_w, sclr_w;

  int checks = 0;
  int errors = 0;

  int          m_left [NI];
  bit          m_pend [NI];
  int          m_rcnt [NI];
  bit          m_clr  [NI];
  logic [15:0] m_frame[NI];
  logic [15:0] col    [NI];
  int          nbits  [NI];
  bit          prev_clk[NI];
  logic        prev_dt [NI];

  always #5 clk = ~clk;

  serial_seg_frame_drv #(.NUM_DIGITS(2), .SEG_W(8), .SCLK_HALF(1), .REFRESH(0), .MSB_FIRST(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .digits(digits), .blank(blank), .update(update), .auto_en(auto_en),
    .busy(busy_w[0]), .done(done_w[0]), .seg_clk(sclk_w[0]), .seg_dt(sdt_w[0]), .seg_en(sen_w[0]), .seg_clr(sclr_w[0]));
  serial_seg_frame_drv #(.NUM_DIGITS(2), .SEG_W(8), .SCLK_HALF(2), .REFRESH(0), .MSB_FIRST(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .digits(digits), .blank(blank), .update(update), .auto_en(auto_en),
    .busy(busy_w[1]), .done(done_w[1]), .seg_clk(sclk_w[1]), .seg_dt(sdt_w[1]), .seg_en(sen_w[1]), .seg_clr(sclr_w[1]));
  serial_seg_frame_drv #(.NUM_DIGITS(2), .SEG_W(8), .SCLK_HALF(1), .REFRESH(50), .MSB_FIRST(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .digits(digits), .blank(blank), .update(update), .auto_en(auto_en),
    .busy(busy_w[2]), .done(done_w[2]), .seg_clk(sclk_w[2]), .seg_dt(sdt_w[2]), .seg_en(sen_w[2]), .seg_clr(sclr_w[2]));
  serial_seg_frame_drv #(.NUM_DIGITS(2), .SEG_W(8), .SCLK_HALF(1), .REFRESH(20), .MSB_FIRST(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .digits(digits), .blank(blank), .update(update), .auto_en(auto_en),
    .busy(busy_w[3]), .done(done_w[3]), .seg_clk(sclk_w[3]), .seg_dt(sdt_w[3]), .seg_en(sen_w[3]), .seg_clr(sclr_w[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] frame_of(input logic [15:0] d, input logic [1:0] b);
    logic [15:0] f;
    for (int k = 0; k < 2; k++) f[k*8 +: 8] = b[k] ? 8'hFF : d[k*8 +: 8];
    return f;
  endfunction

  // Transaction model: a frame occupies 2 + 2*H*NW edges from capture back to idle;
  // requests during that window collapse into one queued start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_left[i] = 0; m_pend[i] = 0; m_rcnt[i] = 0; m_clr[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        bit rreq;
        rreq = 0;
        if (R_P[i] > 0 && auto_en) begin
          if (m_rcnt[i] == R_P[i] - 1) begin m_rcnt[i] = 0; rreq = 1; end
          else m_rcnt[i]++;
        end else m_rcnt[i] = 0;
        m_clr[i] = 1;
        if (m_left[i] > 0) begin
          if (update || rreq) m_pend[i] = 1;
          m_left[i]--;
        end else if (update || rreq || m_pend[i]) begin
          m_pend[i]  = 0;
          m_left[i]  = 2 + 2 * H_P[i] * NW;
          m_frame[i] = frame_of(digits, blank);
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NI; i++) begin
      int lf;
      lf = 2 + 2 * H_P[i] * NW;
      chk($sformatf("busy%0d", i), busy_w[i], m_left[i] > 0);
      chk($sformatf("done%0d", i), done_w[i], m_left[i] == 1);
      chk($sformatf("seg_en%0d", i), sen_w[i], !(m_left[i] >= 2 && m_left[i] <= lf - 1));
      chk($sformatf("seg_clr%0d", i), sclr_w[i], m_clr[i]);
      if (m_left[i] == 0 || m_left[i] == 1 || m_left[i] == lf)
        chk($sformatf("seg_clk_idle%0d", i), sclk_w[i], 1'b1);
      if (!rst_n) begin
        chk($sformatf("seg_dt_rst%0d", i), sdt_w[i], 1'b0);
        nbits[i] = 0;
        col[i]   = '0;
      end else begin
        if (m_left[i] == 0) chk($sformatf("seg_dt_hold%0d", i), sdt_w[i], prev_dt[i]);
        if (!prev_clk[i] && sclk_w[i]) begin
          col[i] = (M_P[i] != 0) ? {col[i][14:0], sdt_w[i]} : {sdt_w[i], col[i][15:1]};
          nbits[i]++;
        end
        if (m_left[i] == 1) begin
          chk($sformatf("nbits%0d", i), nbits[i], NW);
          chk($sformatf("frame%0d", i), col[i], m_frame[i]);
          nbits[i] = 0;
          col[i]   = '0;
        end
      end
      prev_clk[i] = sclk_w[i];
      prev_dt[i]  = sdt_w[i];
    end
  end

  task automatic pulse_update();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic idle_wait(input int limit);
    int n;
    n = 0;
    while (n < limit && (m_left[0] != 0 || m_left[1] != 0 || m_left[2] != 0 || m_left[3] != 0 ||
                         m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3])) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", n < limit, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; digits = '0; blank = '0; update = 1'b0; auto_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_w, '0);
    chk("rst_seg_clk", sclk_w, 4'hF);
    chk("rst_seg_en", sen_w, 4'hF);
    chk("rst_seg_clr", sclr_w, '0);
    rst_n = 1'b1;
    @(negedge clk);

    digits = 16'hC0F9; blank = 2'b00; pulse_update(); idle_wait(400);
    digits = 16'h00A5; pulse_update(); idle_wait(400);
    blank = 2'b01; digits = 16'h1234; pulse_update(); blank = 2'b00; idle_wait(400);

    // Requests mid-transfer, with fresh digits, must give exactly one follow-up frame.
    digits = 16'h0F0F; pulse_update();
    repeat (8) @(negedge clk);
    digits = 16'h5555; pulse_update();
    repeat (3) @(negedge clk);
    pulse_update();
    idle_wait(600);

    auto_en = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
    end
    auto_en = 1'b0;
    idle_wait(600);

    repeat (2000) begin
      @(negedge clk);
      update = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 7) == 0) blank = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
    end
    update = 1'b0; auto_en = 1'b0;
    idle_wait(600);

    // Abort a frame part-way through with an asynchronous reset.
    digits = 16'hA5C3; pulse_update();
    n = 0;
    while (nbits[0] < 7 && n < 200) begin @(negedge clk); n++; end
    chk("abort_point", nbits[0] >= 7, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_seg_clk", sclk_w, 4'hF);
    chk("abort_seg_en", sen_w, 4'hF);
    chk("abort_busy", busy_w, '0);
    chk("abort_done", done_w, '0);
    chk("abort_seg_clr", sclr_w, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_release", sclr_w, 4'hF);
    @(negedge clk);
    digits = 16'h3C96; pulse_update(); idle_wait(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
